ysyx_24100005_mem_arb: RTL and testbench

YSYX_24100005_MEM_ARB -- requirements
Module: ysyx_24100005_mem_arb

---
 rtl/ysyx_24100005_mem_arb.sv | 140 ++++++++++++++
 tb/tb_ysyx_24100005_mem_arb.sv | 398 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ysyx_24100005_mem_arb.sv
// ysyx_24100005_mem_arb: round-robin IFU/LSU arbiter in front of one
// shared memory port, one outstanding transaction, with a wait timeout.
module ysyx_24100005_mem_arb #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ifu_req_valid,
    input  logic [31:0] ifu_addr,
    output logic        ifu_req_ready,
    output logic        ifu_resp_valid,
    output logic [31:0] ifu_rdata,
    input  logic        lsu_req_valid,
    input  logic [31:0] lsu_addr,
    input  logic        lsu_wen,
    input  logic [31:0] lsu_wdata,
    input  logic [3:0]  lsu_wmask,
    output logic        lsu_req_ready,
    output logic        lsu_resp_valid,
    output logic [31:0] lsu_rdata,
    output logic        mem_req_valid,
    output logic [31:0] mem_addr,
    output logic        mem_wen,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wmask,
    input  logic        mem_req_ready,
    input  logic        mem_resp_valid,
    input  logic [31:0] mem_rdata,
    output logic        timeout_err
);

    localparam logic [7:0] TMO = 8'(TIMEOUT);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2
    } state_t;

    state_t      state_q;
    logic        owner_q;
    logic        last_q;
    logic [7:0]  cnt_q;
    logic [31:0] addr_q;
    logic        wen_q;
    logic [31:0] wdata_q;
    logic [3:0]  wmask_q;

    logic in_idle;
    logic in_req;
    logic in_wait;
    logic grant_ifu;
    logic grant_lsu;
    logic tmo_at;
    logic resp_fire;
    logic [31:0] resp_data;

    // Outputs are gated by rst so everything reads zero while reset is held.
    assign in_idle = rst && (state_q == IDLE);
    assign in_req  = rst && (state_q == REQ);
    assign in_wait = rst && (state_q == WAIT);

    // owner_q/last_q: 1 means LSU. A tie goes to whoever was not served last.
    assign grant_ifu = in_idle && ifu_req_valid
                     && (!lsu_req_valid || last_q);
    assign grant_lsu = in_idle && lsu_req_valid
                     && (!ifu_req_valid || !last_q);

    assign tmo_at    = (cnt_q == TMO);
    assign resp_fire = in_wait && (mem_resp_valid || tmo_at);
    assign resp_data = mem_resp_valid ? mem_rdata : 32'h0;

    assign ifu_req_ready  = grant_ifu;
    assign lsu_req_ready  = grant_lsu;
    assign ifu_resp_valid = resp_fire && !owner_q;
    assign lsu_resp_valid = resp_fire && owner_q;
    assign ifu_rdata      = ifu_resp_valid ? resp_data : 32'h0;
    assign lsu_rdata      = lsu_resp_valid ? resp_data : 32'h0;
    // A real response in the timeout cycle wins, so no error then.
    assign timeout_err    = in_wait && !mem_resp_valid && tmo_at;

    assign mem_req_valid = in_req;
    assign mem_addr      = addr_q;
    assign mem_wen       = wen_q;
    assign mem_wdata     = wdata_q;
    assign mem_wmask     = wmask_q;

    // Transaction FSM: grant in IDLE, present in REQ, collect in WAIT.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
            owner_q <= 1'b0;
            last_q  <= 1'b1;
            cnt_q   <= 8'h0;
            addr_q  <= 32'h0;
            wen_q   <= 1'b0;
            wdata_q <= 32'h0;
            wmask_q <= 4'h0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (grant_ifu) begin
                        state_q <= REQ;
                        owner_q <= 1'b0;
                        last_q  <= 1'b0;
                        addr_q  <= ifu_addr;
                        wen_q   <= 1'b0;
                        wdata_q <= 32'h0;
                        wmask_q <= 4'h0;
                    end else if (grant_lsu) begin
                        state_q <= REQ;
                        owner_q <= 1'b1;
                        last_q  <= 1'b1;
                        addr_q  <= lsu_addr;
                        wen_q   <= lsu_wen;
                        wdata_q <= lsu_wdata;
                        wmask_q <= lsu_wmask;
                    end
                end
                REQ: begin
                    if (mem_req_ready) begin
                        state_q <= WAIT;
                        cnt_q   <= 8'h0;
                    end
                end
                WAIT: begin
                    if (resp_fire) begin
                        state_q <= IDLE;
                    end else begin
                        cnt_q <= cnt_q + 8'h1;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ysyx_24100005_mem_arb.sv
// tb_ysyx_24100005_mem_arb: directed scenarios plus random traffic,
// checked every cycle against a transaction-level reference model.
module tb_ysyx_24100005_mem_arb;

    localparam int TMO = 4;

    logic        clk;
    logic        rst;
    logic        ifu_req_valid;
    logic [31:0] ifu_addr;
    logic        ifu_req_ready;
    logic        ifu_resp_valid;
    logic [31:0] ifu_rdata;
    logic        lsu_req_valid;
    logic [31:0] lsu_addr;
    logic        lsu_wen;
    logic [31:0] lsu_wdata;
    logic [3:0]  lsu_wmask;
    logic        lsu_req_ready;
    logic        lsu_resp_valid;
    logic [31:0] lsu_rdata;
    logic        mem_req_valid;
    logic [31:0] mem_addr;
    logic        mem_wen;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wmask;
    logic        mem_req_ready;
    logic        mem_resp_valid;
    logic [31:0] mem_rdata;
    logic        timeout_err;

    int vectors;
    int miscompares;

    // Reference model: the one pending transaction as a record.
    bit          m_act;
    bit          m_sent;
    bit          m_own;
    bit          m_last_lsu;
    int          m_age;
    logic [31:0] m_addr;
    logic        m_wen;
    logic [31:0] m_wdata;
    logic [3:0]  m_wmask;

    // Values seen at the last sampling point, for directed checks.
    logic        cap_iready;
    logic        cap_lready;
    logic        cap_mvalid;
    logic [31:0] cap_maddr;
    logic        cap_mwen;
    logic [31:0] cap_mwdata;
    logic [3:0]  cap_mwmask;
    logic        cap_iresp;
    logic        cap_lresp;
    logic [31:0] cap_irdata;
    logic [31:0] cap_lrdata;
    logic        cap_err;

    bit dut_grants[$];

    ysyx_24100005_mem_arb #(.TIMEOUT(TMO)) dut (
        .clk            (clk),
        .rst            (rst),
        .ifu_req_valid  (ifu_req_valid),
        .ifu_addr       (ifu_addr),
        .ifu_req_ready  (ifu_req_ready),
        .ifu_resp_valid (ifu_resp_valid),
        .ifu_rdata      (ifu_rdata),
        .lsu_req_valid  (lsu_req_valid),
        .lsu_addr       (lsu_addr),
        .lsu_wen        (lsu_wen),
        .lsu_wdata      (lsu_wdata),
        .lsu_wmask      (lsu_wmask),
        .lsu_req_ready  (lsu_req_ready),
        .lsu_resp_valid (lsu_resp_valid),
        .lsu_rdata      (lsu_rdata),
        .mem_req_valid  (mem_req_valid),
        .mem_addr       (mem_addr),
        .mem_wen        (mem_wen),
        .mem_wdata      (mem_wdata),
        .mem_wmask      (mem_wmask),
        .mem_req_ready  (mem_req_ready),
        .mem_resp_valid (mem_resp_valid),
        .mem_rdata      (mem_rdata),
        .timeout_err    (timeout_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock: check outputs at the falling edge, advance model at rise.
    task automatic cycle();
        bit          any;
        bit          win_lsu;
        bit          fire;
        bit          e_ir;
        bit          e_lr;
        bit          e_mv;
        bit          e_ip;
        bit          e_lp;
        bit          e_er;
        logic [31:0] e_rd;
        @(negedge clk);
        any     = 1'b0;
        win_lsu = 1'b0;
        if (!m_act && (ifu_req_valid || lsu_req_valid)) begin
            any = 1'b1;
            if (ifu_req_valid && lsu_req_valid)
                win_lsu = !m_last_lsu;
            else
                win_lsu = lsu_req_valid;
        end
        fire = m_act && m_sent && (mem_resp_valid || m_age == TMO);
        e_ir = rst && any && !win_lsu;
        e_lr = rst && any && win_lsu;
        e_mv = rst && m_act && !m_sent;
        e_ip = rst && fire && !m_own;
        e_lp = rst && fire && m_own;
        e_er = rst && fire && !mem_resp_valid;
        e_rd = mem_resp_valid ? mem_rdata : 32'h0;

        cap_iready = ifu_req_ready;
        cap_lready = lsu_req_ready;
        cap_mvalid = mem_req_valid;
        cap_maddr  = mem_addr;
        cap_mwen   = mem_wen;
        cap_mwdata = mem_wdata;
        cap_mwmask = mem_wmask;
        cap_iresp  = ifu_resp_valid;
        cap_lresp  = lsu_resp_valid;
        cap_irdata = ifu_rdata;
        cap_lrdata = lsu_rdata;
        cap_err    = timeout_err;
        if (ifu_req_ready === 1'b1) dut_grants.push_back(1'b0);
        if (lsu_req_ready === 1'b1) dut_grants.push_back(1'b1);

        chk("ifu_req_ready", 32'(ifu_req_ready), 32'(e_ir));
        chk("lsu_req_ready", 32'(lsu_req_ready), 32'(e_lr));
        chk("mem_req_valid", 32'(mem_req_valid), 32'(e_mv));
        chk("ifu_resp_valid", 32'(ifu_resp_valid), 32'(e_ip));
        chk("lsu_resp_valid", 32'(lsu_resp_valid), 32'(e_lp));
        chk("timeout_err", 32'(timeout_err), 32'(e_er));
        if (e_mv) begin
            chk("mem_addr", mem_addr, m_addr);
            chk("mem_wen", 32'(mem_wen), 32'(m_wen));
            chk("mem_wmask", 32'(mem_wmask), 32'(m_wmask));
            if (m_wen) chk("mem_wdata", mem_wdata, m_wdata);
        end
        if (e_ip) chk("ifu_rdata", ifu_rdata, e_rd);
        if (e_lp) chk("lsu_rdata", lsu_rdata, e_rd);
        if (!rst) begin
            chk("rst_ifu_rdata", ifu_rdata, 32'h0);
            chk("rst_lsu_rdata", lsu_rdata, 32'h0);
        end

        @(posedge clk);
        if (!rst) begin
            m_act      = 1'b0;
            m_sent     = 1'b0;
            m_age      = 0;
            m_last_lsu = 1'b1;
        end else if (!m_act) begin
            if (any) begin
                m_act      = 1'b1;
                m_sent     = 1'b0;
                m_own      = win_lsu;
                m_last_lsu = win_lsu;
                m_addr     = win_lsu ? lsu_addr : ifu_addr;
                m_wen      = win_lsu ? lsu_wen : 1'b0;
                m_wdata    = win_lsu ? lsu_wdata : 32'h0;
                m_wmask    = win_lsu ? lsu_wmask : 4'h0;
            end
        end else if (!m_sent) begin
            if (mem_req_ready) begin
                m_sent = 1'b1;
                m_age  = 0;
            end
        end else if (fire) begin
            m_act = 1'b0;
        end else begin
            m_age++;
        end
        #1;
    endtask

    task automatic quiet();
        ifu_req_valid  = 1'b0;
        lsu_req_valid  = 1'b0;
        mem_req_ready  = 1'b0;
        mem_resp_valid = 1'b0;
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        m_act       = 1'b0;
        m_sent      = 1'b0;
        m_own       = 1'b0;
        m_last_lsu  = 1'b1;
        m_age       = 0;
        m_addr      = 32'h0;
        m_wen       = 1'b0;
        m_wdata     = 32'h0;
        m_wmask     = 4'h0;
        rst         = 1'b0;
        ifu_addr    = 32'h0;
        lsu_addr    = 32'h0;
        lsu_wen     = 1'b0;
        lsu_wdata   = 32'h0;
        lsu_wmask   = 4'h0;
        mem_rdata   = 32'h0;
        quiet();

        // Reset held with busy inputs: outputs must all stay zero.
        ifu_req_valid  = 1'b1;
        lsu_req_valid  = 1'b1;
        mem_resp_valid = 1'b1;
        mem_rdata      = 32'h1234_5678;
        repeat (3) cycle();
        quiet();
        rst = 1'b1;
        cycle();

        // Basic fetch with minimum latency.
        ifu_req_valid = 1'b1;
        ifu_addr      = 32'h8000_0000;
        mem_req_ready = 1'b1;
        cycle();
        chk("fetch_accept", 32'(cap_iready), 32'h1);
        ifu_req_valid = 1'b0;
        cycle();
        chk("fetch_mem_addr", cap_maddr, 32'h8000_0000);
        mem_resp_valid = 1'b1;
        mem_rdata      = 32'h0000_0413;
        cycle();
        chk("fetch_resp", 32'(cap_iresp), 32'h1);
        chk("fetch_rdata", cap_irdata, 32'h0000_0413);
        quiet();
        cycle();

        // Contention: grants alternate starting with IFU after reset.
        rst = 1'b0;
        repeat (2) cycle();
        rst = 1'b1;
        dut_grants.delete();
        ifu_req_valid  = 1'b1;
        lsu_req_valid  = 1'b1;
        lsu_wen        = 1'b0;
        mem_req_ready  = 1'b1;
        mem_resp_valid = 1'b1;
        repeat (12) cycle();
        quiet();
        cycle();
        chk("rr_count", 32'(dut_grants.size()), 32'd4);
        if (dut_grants.size() == 4) begin
            chk("rr_g0", 32'(dut_grants[0]), 32'd0);
            chk("rr_g1", 32'(dut_grants[1]), 32'd1);
            chk("rr_g2", 32'(dut_grants[2]), 32'd0);
            chk("rr_g3", 32'(dut_grants[3]), 32'd1);
        end

        // Store with memory back-pressure for three cycles.
        lsu_req_valid = 1'b1;
        lsu_addr      = 32'h8000_1000;
        lsu_wen       = 1'b1;
        lsu_wdata     = 32'hDEAD_BEEF;
        lsu_wmask     = 4'hF;
        cycle();
        chk("st_accept", 32'(cap_lready), 32'h1);
        lsu_req_valid = 1'b0;
        lsu_addr      = 32'h0;
        lsu_wdata     = 32'h0;
        for (int i = 0; i < 4; i++) begin
            mem_req_ready = (i == 3);
            cycle();
            chk("st_mvalid", 32'(cap_mvalid), 32'h1);
            chk("st_addr", cap_maddr, 32'h8000_1000);
            chk("st_wdata", cap_mwdata, 32'hDEAD_BEEF);
            chk("st_wen", 32'(cap_mwen), 32'h1);
            chk("st_wmask", 32'(cap_mwmask), 32'hF);
        end
        mem_req_ready  = 1'b0;
        mem_resp_valid = 1'b1;
        mem_rdata      = 32'h5555_AAAA;
        cycle();
        chk("st_ack", 32'(cap_lresp), 32'h1);
        chk("st_rdata", cap_lrdata, 32'h5555_AAAA);
        quiet();
        cycle();

        // Timeout with no response: fires exactly TMO cycles into WAIT.
        ifu_req_valid = 1'b1;
        ifu_addr      = 32'h8000_0040;
        mem_req_ready = 1'b1;
        cycle();
        ifu_req_valid = 1'b0;
        cycle();
        mem_req_ready = 1'b0;
        mem_rdata     = 32'hFFFF_FFFF;
        for (int i = 0; i < TMO; i++) begin
            cycle();
            chk("tmo_early", 32'(cap_iresp), 32'h0);
        end
        cycle();
        chk("tmo_resp", 32'(cap_iresp), 32'h1);
        chk("tmo_err", 32'(cap_err), 32'h1);
        chk("tmo_rdata", cap_irdata, 32'h0);
        cycle();
        chk("tmo_pulse", 32'(cap_err), 32'h0);

        // Response arriving in the timeout cycle wins.
        lsu_req_valid = 1'b1;
        lsu_wen       = 1'b0;
        lsu_addr      = 32'h8000_2000;
        mem_req_ready = 1'b1;
        cycle();
        lsu_req_valid = 1'b0;
        cycle();
        mem_req_ready = 1'b0;
        repeat (TMO) cycle();
        mem_resp_valid = 1'b1;
        mem_rdata      = 32'hCAFE_F00D;
        cycle();
        chk("race_resp", 32'(cap_lresp), 32'h1);
        chk("race_rdata", cap_lrdata, 32'hCAFE_F00D);
        chk("race_err", 32'(cap_err), 32'h0);
        quiet();
        cycle();

        // Reset during WAIT abandons the load; stray response ignored.
        lsu_req_valid = 1'b1;
        lsu_addr      = 32'h8000_3000;
        mem_req_ready = 1'b1;
        cycle();
        lsu_req_valid = 1'b0;
        cycle();
        mem_req_ready = 1'b0;
        cycle();
        rst = 1'b0;
        cycle();
        rst            = 1'b1;
        mem_resp_valid = 1'b1;
        mem_rdata      = 32'h0BAD_0BAD;
        repeat (2) begin
            cycle();
            chk("stray_lsu", 32'(cap_lresp), 32'h0);
            chk("stray_ifu", 32'(cap_iresp), 32'h0);
        end
        mem_resp_valid = 1'b0;
        ifu_req_valid  = 1'b1;
        ifu_addr       = 32'h8000_0100;
        mem_req_ready  = 1'b1;
        cycle();
        chk("post_rst_accept", 32'(cap_iready), 32'h1);
        ifu_req_valid = 1'b0;
        cycle();
        mem_resp_valid = 1'b1;
        mem_rdata      = 32'h0010_0093;
        cycle();
        chk("post_rst_resp", 32'(cap_iresp), 32'h1);
        chk("post_rst_rdata", cap_irdata, 32'h0010_0093);
        quiet();
        cycle();

        // Random traffic, including rare mid-run resets.
        for (int i = 0; i < 400; i++) begin
            rst            = ($urandom_range(0, 49) != 0);
            ifu_req_valid  = ($urandom_range(0, 2) != 0);
            ifu_addr       = $urandom;
            lsu_req_valid  = ($urandom_range(0, 2) != 0);
            lsu_addr       = $urandom;
            lsu_wen        = 1'($urandom_range(0, 1));
            lsu_wdata      = $urandom;
            lsu_wmask      = 4'($urandom_range(0, 15));
            mem_req_ready  = ($urandom_range(0, 2) != 0);
            mem_resp_valid = ($urandom_range(0, 3) == 0);
            mem_rdata      = $urandom;
            cycle();
        end

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
